// File: rtl/draw_pkg.sv
// Shared definitions for the frame renderer: default screen geometry, colour width,
// FSM state encoding and the reset/idle pixel colour.
package draw_pkg;

    localparam int DEF_H_RES   = 160;
    localparam int DEF_V_RES   = 120;
    localparam int DEF_COLOR_W = 3;

    localparam logic [DEF_COLOR_W-1:0] BLACK = '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_CALC,
        S_DRAW
    } draw_state_t;

endpackage

// File: rtl/column_span_calc.sv
// Combinational column geometry: clamps the wall height, centres the wall vertically
// and picks ceiling / wall / floor colour for one row of an already-computed span.
module column_span_calc
    import draw_pkg::*;
#(
    parameter int V_RES   = DEF_V_RES,
    parameter int YW      = 7,
    parameter int HW      = 8,
    parameter int COLOR_W = DEF_COLOR_W
) (
    input  logic [HW-1:0]      slice_height,
    input  logic               slice_skip,
    output logic [YW:0]        span_h,
    output logic [YW-1:0]      span_top,
    input  logic [YW-1:0]      row,
    input  logic [YW-1:0]      row_top,
    input  logic [YW:0]        row_h,
    input  logic [COLOR_W-1:0] ceil_color,
    input  logic [COLOR_W-1:0] wall_color,
    input  logic [COLOR_W-1:0] floor_color,
    output logic [COLOR_W-1:0] pixel_color
);

    logic [YW:0] gap;
    logic [YW:0] row_ext;
    logic [YW:0] wall_end;

    // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        span_h = (YW+1)'(V_RES);
        if (slice_skip) begin
            span_h = '0;
        end else if (int'(slice_height) < V_RES) begin
            span_h = (YW+1)'(slice_height);
        end
    end

    // Floor division: an odd leftover places the wall half a pixel high.
    assign gap      = (YW+1)'(V_RES) - span_h;
    assign span_top = YW'(gap >> 1);

    // One extra bit so top + h never wraps even when V_RES == 2**YW.
    assign row_ext  = {1'b0, row};
    assign wall_end = {1'b0, row_top} + row_h;

    always_comb begin
        pixel_color = floor_color;
        if (row_ext < {1'b0, row_top}) begin
            pixel_color = ceil_color;
        end else if (row_ext < wall_end) begin
            pixel_color = wall_color;
        end
    end

endmodule

// File: rtl/frame_column_renderer.sv
// Raycast frame renderer: fetches one slice per column and writes every pixel of it.
// Optional FRAME_SIDE_SHADE_EN adds slice_side / wall_alt_color for side-shaded walls.
module frame_column_renderer
    import draw_pkg::*;
#(
    parameter int H_RES   = DEF_H_RES,
    parameter int V_RES   = DEF_V_RES,
    parameter int XW      = 8,
    parameter int YW      = 7,
    parameter int HW      = 8,
    parameter int COLOR_W = DEF_COLOR_W
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               frame_start,
    input  logic [COLOR_W-1:0] ceil_color,
    input  logic [COLOR_W-1:0] floor_color,
    output logic               slice_req,
    output logic [XW-1:0]      slice_col,
    input  logic               slice_ack,
    input  logic [HW-1:0]      slice_height,
    input  logic [COLOR_W-1:0] slice_color,
    input  logic               slice_skip,
`ifdef FRAME_SIDE_SHADE_EN
    input  logic               slice_side,
    input  logic [COLOR_W-1:0] wall_alt_color,
`endif
    input  logic               plot_ready,
    output logic               plot,
    output logic [XW-1:0]      x,
    output logic [YW-1:0]      y,
    output logic [COLOR_W-1:0] color,
    output logic               busy,
    output logic               frame_done,
    output logic               frame_dropped
);

    draw_state_t state_q, state_d;

    logic               frame_start_q;
    logic               start_edge;
    logic [XW-1:0]      col_q;
    logic [YW-1:0]      row_q;
    logic [COLOR_W-1:0] ceil_q, floor_q, wall_color_q;
    logic [HW-1:0]      height_q;
    logic               skip_q;
    logic [YW-1:0]      top_q;
    logic [YW:0]        h_q;
    logic               frame_done_q, frame_dropped_q;

    logic               pixel_accept;
    logic               last_row, last_col;
    logic [YW:0]        span_h;
    logic [YW-1:0]      span_top;
    logic [COLOR_W-1:0] pixel_color;

    assign start_edge   = frame_start & ~frame_start_q;
    assign pixel_accept = (state_q == S_DRAW) && plot_ready;
    assign last_row     = (row_q == YW'(V_RES - 1));
    assign last_col     = (col_q == XW'(H_RES - 1));

    column_span_calc #(
        .V_RES   (V_RES),
        .YW      (YW),
        .HW      (HW),
        .COLOR_W (COLOR_W)
    ) u_span (
        .slice_height (height_q),
        .slice_skip   (skip_q),
        .span_h       (span_h),
        .span_top     (span_top),
        .row          (row_q),
        .row_top      (top_q),
        .row_h        (h_q),
        .ceil_color   (ceil_q),
        .wall_color   (wall_color_q),
        .floor_color  (floor_q),
        .pixel_color  (pixel_color)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_edge) state_d = S_REQ;
            S_REQ:  if (slice_ack) state_d = S_CALC;
            S_CALC: state_d = S_DRAW;
            S_DRAW: begin
                if (pixel_accept && last_row) begin
                    state_d = last_col ? S_IDLE : S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q         <= S_IDLE;
            frame_start_q   <= 1'b0;
            col_q           <= '0;
            row_q           <= '0;
            ceil_q          <= '0;
            floor_q         <= '0;
            wall_color_q    <= '0;
            height_q        <= '0;
            skip_q          <= 1'b0;
            top_q           <= '0;
            h_q             <= '0;
            frame_done_q    <= 1'b0;
            frame_dropped_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            frame_start_q   <= frame_start;
            frame_done_q    <= pixel_accept && last_row && last_col;
            frame_dropped_q <= start_edge && (state_q != S_IDLE);

            case (state_q)
                S_IDLE: begin
                    if (start_edge) begin
                        ceil_q  <= ceil_color;
                        floor_q <= floor_color;
                        col_q   <= '0;
                    end
                end
                S_REQ: begin
                    if (slice_ack) begin
                        height_q <= slice_height;
                        skip_q   <= slice_skip;
`ifdef FRAME_SIDE_SHADE_EN
                        wall_color_q <= slice_side ? wall_alt_color : slice_color;
`else
                        wall_color_q <= slice_color;
`endif
                    end
                end
                S_CALC: begin
                    top_q <= span_top;
                    h_q   <= span_h;
                    row_q <= '0;
                end
                S_DRAW: begin
                    if (pixel_accept) begin
                        if (last_row) begin
                            row_q <= '0;
                            if (!last_col) col_q <= col_q + XW'(1);
                        end else begin
                            row_q <= row_q + YW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode straight from registers, so they hold steady across a stall
    // and collapse immediately on reset.
    assign slice_req     = (state_q == S_REQ);
    assign slice_col     = col_q;
    assign busy          = (state_q != S_IDLE);
    assign plot          = (state_q == S_DRAW);
    assign x             = col_q;
    assign y             = row_q;
    assign color         = plot ? pixel_color : COLOR_W'(BLACK);
    assign frame_done    = frame_done_q;
    assign frame_dropped = frame_dropped_q;

endmodule

// File: tb/tb_frame_column_renderer.sv
// Self-checking bench for frame_column_renderer: table-driven column geometry plus
// directed sequences for backpressure, ack latency, dropped frames and mid-frame reset.
module tb_frame_column_renderer;

    localparam int H_RES = 160;
    localparam int V_RES = 120;
    localparam int NPIX  = H_RES * V_RES;
    localparam logic [2:0] ALT_COLOR = 3'b011;

    typedef struct {
        logic [7:0] height;
        logic       skip;
        logic [2:0] wcolor;
        logic       side;
        int         exp_top;
        int         exp_h;
    } vec_t;

    vec_t vec [10];

    logic       clock, resetn, frame_start;
    logic [2:0] ceil_color, floor_color;
    logic       slice_req, slice_ack, slice_skip;
    logic [7:0] slice_col, slice_height;
    logic [2:0] slice_color;
`ifdef FRAME_SIDE_SHADE_EN
    logic       slice_side;
    logic [2:0] wall_alt_color;
`endif
    logic       plot_ready, plot, busy, frame_done, frame_dropped;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] color;

    frame_column_renderer dut (
        .clock         (clock),
        .resetn        (resetn),
        .frame_start   (frame_start),
        .ceil_color    (ceil_color),
        .floor_color   (floor_color),
        .slice_req     (slice_req),
        .slice_col     (slice_col),
        .slice_ack     (slice_ack),
        .slice_height  (slice_height),
        .slice_color   (slice_color),
        .slice_skip    (slice_skip),
`ifdef FRAME_SIDE_SHADE_EN
        .slice_side    (slice_side),
        .wall_alt_color(wall_alt_color),
`endif
        .plot_ready    (plot_ready),
        .plot          (plot),
        .x             (x),
        .y             (y),
        .color         (color),
        .busy          (busy),
        .frame_done    (frame_done),
        .frame_dropped (frame_dropped)
    );

    initial begin
        clock = 1'b0;
        forever #10 clock = ~clock;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bench-side stimulus controls and per-frame bookkeeping.
    bit         ready_rand = 0;
    bit         ack_rand   = 0;
    int         fixed_delay = 1;
    bit         mon_en = 0;
    logic [2:0] cur_ceil, cur_floor;
    int         pix_cnt, done_cnt, drop_cnt;
    bit         seen [NPIX];

    function automatic logic [2:0] exp_pixel(input int xx, input int yy);
        vec_t       v;
        logic [2:0] wall;
        v    = vec[xx % 10];
        wall = v.wcolor;
`ifdef FRAME_SIDE_SHADE_EN
        if (v.side) wall = ALT_COLOR;
`endif
        if (yy < v.exp_top) return cur_ceil;
        if (yy < v.exp_top + v.exp_h) return wall;
        return cur_floor;
    endfunction

    task automatic new_frame(input logic [2:0] c, input logic [2:0] f);
        ceil_color  = c;
        floor_color = f;
        cur_ceil    = c;
        cur_floor   = f;
        pix_cnt     = 0;
        done_cnt    = 0;
        drop_cnt    = 0;
        for (int i = 0; i < NPIX; i++) seen[i] = 1'b0;
    endtask

    task automatic end_frame(input string tag, input int exp_drops);
        int missing;
        missing = 0;
        for (int i = 0; i < NPIX; i++) if (!seen[i]) missing++;
        check({tag, "_pixels"}, pix_cnt, NPIX);
        check({tag, "_missing"}, missing, 0);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_drops"}, drop_cnt, exp_drops);
    endtask

    task automatic wait_done(input int limit, output bit ok);
        int n;
        ok = 0;
        n  = 0;
        while (!ok && n < limit) begin
            @(negedge clock);
            n++;
            ok = frame_done;
        end
    endtask

    task automatic wait_req(input int col, input int limit, output bit ok);
        int n;
        ok = 0;
        n  = 0;
        while (!ok && n < limit) begin
            @(negedge clock);
            n++;
            ok = slice_req && (int'(slice_col) == col);
        end
    endtask

    // Slice source: answers each request after a fixed or random latency and
    // drives junk on the data lines whenever no ack is being given.
    initial begin : responder
        bit in_req;
        int wait_cnt, cur_delay;
        in_req = 0; wait_cnt = 0; cur_delay = 0;
        slice_ack = 1'b0; slice_height = '0; slice_color = '0; slice_skip = 1'b0;
`ifdef FRAME_SIDE_SHADE_EN
        slice_side = 1'b0; wall_alt_color = '0;
`endif
        forever begin
            @(posedge clock);
            #2;
            slice_ack    = 1'b0;
            slice_height = 8'($urandom);
            slice_color  = 3'($urandom);
            slice_skip   = 1'($urandom);
`ifdef FRAME_SIDE_SHADE_EN
            slice_side     = 1'($urandom);
            wall_alt_color = 3'($urandom);
`endif
            if (slice_req) begin
                if (!in_req) begin
                    in_req    = 1;
                    wait_cnt  = 0;
                    cur_delay = ack_rand ? int'($urandom_range(7, 0)) : fixed_delay;
                end
                if (wait_cnt >= cur_delay) begin
                    slice_ack    = 1'b1;
                    slice_height = vec[int'(slice_col) % 10].height;
                    slice_color  = vec[int'(slice_col) % 10].wcolor;
                    slice_skip   = vec[int'(slice_col) % 10].skip;
`ifdef FRAME_SIDE_SHADE_EN
                    slice_side     = vec[int'(slice_col) % 10].side;
                    wall_alt_color = ALT_COLOR;
`endif
                end else begin
                    wait_cnt++;
                end
            end else begin
                in_req = 0;
            end
        end
    end

    initial begin : ready_driver
        plot_ready = 1'b1;
        forever begin
            @(posedge clock);
            #2;
            plot_ready = ready_rand ? ($urandom_range(99, 0) >= 30) : 1'b1;
        end
    end

    // Monitor on the falling edge: pixel scoreboard, stall stability, request handshake.
    logic       prev_plot, prev_ready, prev_req, prev_ack;
    logic [7:0] prev_x;
    logic [6:0] prev_y;
    logic [2:0] prev_color;

    initial begin
        prev_plot = 0; prev_ready = 0; prev_req = 0; prev_ack = 0;
        prev_x = 0; prev_y = 0; prev_color = 0;
    end

    always @(negedge clock) begin
        if (mon_en) begin
            if (prev_plot && !prev_ready) begin
                check("stall_plot", plot, 1'b1);
                check("stall_x", x, prev_x);
                check("stall_y", y, prev_y);
                check("stall_color", color, prev_color);
            end
            if (prev_req && !prev_ack) check("req_held", slice_req, 1'b1);
            if (prev_req && prev_ack) begin
                check("req_drop_after_ack", slice_req, 1'b0);
                check("no_plot_in_calc", plot, 1'b0);
            end
            if (slice_req) check("no_plot_in_req", plot, 1'b0);
            if (plot && plot_ready) begin
                if (int'(x) < H_RES && int'(y) < V_RES) begin
                    check("pixel_dup", seen[int'(x) * V_RES + int'(y)], 1'b0);
                    seen[int'(x) * V_RES + int'(y)] = 1'b1;
                    check("pixel_color", color, exp_pixel(int'(x), int'(y)));
                end else begin
                    check("pixel_in_range", 0, 1);
                end
                pix_cnt++;
            end
            if (frame_done) begin
                done_cnt++;
                check("busy_low_at_done", busy, 1'b0);
            end
            if (frame_dropped) drop_cnt++;
        end
        prev_plot  = plot;
        prev_ready = plot_ready;
        prev_req   = slice_req;
        prev_ack   = slice_ack;
        prev_x     = x;
        prev_y     = y;
        prev_color = color;
    end

    initial begin : main
        bit ok;
        int cyc;

        // Hand-computed geometry: top = (120 - h) >> 1, h = skip ? 0 : min(height, 120).
        vec[0] = '{8'd60,  1'b0, 3'b100, 1'b0, 30, 60};
        vec[1] = '{8'd200, 1'b0, 3'b101, 1'b0, 0,  120};
        vec[2] = '{8'd1,   1'b0, 3'b110, 1'b0, 59, 1};
        vec[3] = '{8'd80,  1'b1, 3'b111, 1'b0, 60, 0};
        vec[4] = '{8'd120, 1'b0, 3'b011, 1'b0, 0,  120};
        vec[5] = '{8'd0,   1'b0, 3'b100, 1'b0, 60, 0};
        vec[6] = '{8'd121, 1'b0, 3'b001, 1'b0, 0,  120};
        vec[7] = '{8'd3,   1'b0, 3'b110, 1'b1, 58, 3};
        vec[8] = '{8'd255, 1'b0, 3'b010, 1'b0, 0,  120};
        vec[9] = '{8'd119, 1'b0, 3'b101, 1'b0, 0,  119};

        resetn = 1'b0;
        frame_start = 1'b0;
        new_frame(3'b001, 3'b010);
        #5;
        check("rst_plot", plot, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_req", slice_req, 1'b0);
        check("rst_done", frame_done, 1'b0);
        check("rst_dropped", frame_dropped, 1'b0);
        check("rst_col", slice_col, 8'd0);
        check("rst_x", x, 8'd0);
        check("rst_y", y, 7'd0);
        check("rst_color", color, 3'd0);
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        repeat (2) @(negedge clock);

        // Frame 1: full speed, ack one cycle after request, colours changed after the edge.
        fixed_delay = 1;
        new_frame(3'b001, 3'b010);
        mon_en = 1;
        @(negedge clock);
        frame_start = 1'b1;
        cyc = 0;
        ok  = 0;
        while (!ok && cyc < 25000) begin
            @(posedge clock);
            cyc++;
            #1;
            if (cyc == 1) begin
                check("f1_busy_with_req", busy, 1'b1);
                check("f1_req_first", slice_req, 1'b1);
                check("f1_col_first", slice_col, 8'd0);
            end
            if (cyc == 3) begin
                frame_start = 1'b0;
                ceil_color  = 3'b111;
                floor_color = 3'b111;
            end
            ok = frame_done;
        end
        check("f1_done_seen", ok, 1'b1);
        check("f1_done_latency", cyc, 160 * 123 + 1);
        @(posedge clock);
        #1;
        check("f1_done_one_cycle", frame_done, 1'b0);
        @(negedge clock);
        end_frame("f1", 0);

        // Frame 2: 30% stall rate and random 0-7 cycle ack latency.
        ready_rand = 1;
        ack_rand   = 1;
        new_frame(3'b110, 3'b011);
        @(negedge clock);
        frame_start = 1'b1;
        repeat (4) @(negedge clock);
        frame_start = 1'b0;
        wait_done(60000, ok);
        check("f2_done_seen", ok, 1'b1);
        ready_rand = 0;
        ack_rand   = 0;
        repeat (2) @(negedge clock);
        end_frame("f2", 0);

        // Frame 3: a second edge at column 50 is dropped, then a new edge lands in the done cycle.
        fixed_delay = 0;
        new_frame(3'b010, 3'b001);
        @(negedge clock);
        frame_start = 1'b1;
        repeat (4) @(negedge clock);
        frame_start = 1'b0;
        wait_req(50, 10000, ok);
        check("f3_reached_col50", ok, 1'b1);
        frame_start = 1'b1;
        repeat (3) @(negedge clock);
        check("f3_busy_after_drop", busy, 1'b1);
        check("f3_drop_count", drop_cnt, 1);
        frame_start = 1'b0;
        wait_done(25000, ok);
        check("f3_done_seen", ok, 1'b1);
        frame_start = 1'b1;
        @(posedge clock);
        #1;
        check("f4_start_in_done_cycle", busy, 1'b1);
        check("f4_req", slice_req, 1'b1);
        check("f4_col0", slice_col, 8'd0);
        check("f4_not_dropped", frame_dropped, 1'b0);
        end_frame("f3", 1);
        new_frame(3'b010, 3'b001);
        repeat (3) @(negedge clock);
        frame_start = 1'b0;

        // Frame 4: reset in the middle of column 80.
        wait_req(80, 12000, ok);
        check("f4_reached_col80", ok, 1'b1);
        repeat (40) @(negedge clock);
        check("f4_drawing_before_reset", plot, 1'b1);
        mon_en = 0;
        #2;
        resetn = 1'b0;
        #1;
        check("mid_rst_plot", plot, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_req", slice_req, 1'b0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        repeat (2) @(negedge clock);

        // Frame 5: restart after reset begins at column 0.
        new_frame(3'b101, 3'b000);
        mon_en = 1;
        frame_start = 1'b1;
        @(posedge clock);
        #1;
        check("f5_col0", slice_col, 8'd0);
        check("f5_req", slice_req, 1'b1);
        cyc = 0;
        while (!plot && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        check("f5_first_plot", plot, 1'b1);
        check("f5_first_x", x, 8'd0);
        check("f5_first_y", y, 7'd0);
        frame_start = 1'b0;
        wait_req(2, 1000, ok);
        check("f5_reached_col2", ok, 1'b1);
        check("f5_two_columns", pix_cnt, 2 * V_RES);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
